// File: rtl/seq_add32.sv
// Multi-cycle 32-bit add/subtract: three 12-bit slices through one shared ripple adder,
// with the carry chained through a register between slices.

module _12bit_adder (
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic        cin,
  output logic [11:0] s,
  output logic        cout
);
  logic carry;

  always_comb begin
    s     = '0;
    carry = cin;
    for (int i = 0; i < 12; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end
endmodule

// state | meaning
// IDLE  | ready for start; operands latched on accept
// S0    | add bits [11:0]
// S1    | add bits [23:12]
// S2    | add bits [31:24], commit result and flags, pulse done
module seq_add32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry_out,
  output logic        overflow,
  output logic        zero
);
  typedef enum logic [1:0] {IDLE, S0, S1, S2} state_t;

  state_t      state_q, state_d;
  logic [31:0] op_a, op_b;
  logic [23:0] tmp;
  logic        cy;
  logic [11:0] add_a, add_b, add_s;
  logic        add_c;

  _12bit_adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (cy),
    .s    (add_s),
    .cout (add_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = S0;
      S0:      state_d = S1;
      S1:      state_d = S2;
      S2:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign busy  = ~ready;

  // Top slice is only 8 bits wide; zero-extending puts the bit-32 carry on s[8].
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state_q)
      S0:      begin add_a = op_a[11:0];          add_b = op_b[11:0];          end
      S1:      begin add_a = op_a[23:12];         add_b = op_b[23:12];         end
      S2:      begin add_a = {4'b0, op_a[31:24]}; add_b = {4'b0, op_b[31:24]}; end
      default: begin add_a = '0;                  add_b = '0;                  end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      tmp       <= '0;
      cy        <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_a <= a;
            op_b <= sub ? ~b : b;
            cy   <= sub;
          end
        end
        S0: begin
          tmp[11:0] <= add_s;
          cy        <= add_c;
        end
        S1: begin
          tmp[23:12] <= add_s;
          cy         <= add_c;
        end
        S2: begin
          result    <= {add_s[7:0], tmp};
          carry_out <= add_s[8];
          overflow  <= (op_a[31] == op_b[31]) && (add_s[7] != op_a[31]);
          zero      <= ({add_s[7:0], tmp} == 32'd0);
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_add32.sv
// Scoreboard bench for seq_add32: stimulus pushes expected completions, a monitor pops on done.

module tb_seq_add32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        ready, busy, done, carry_out, overflow, zero;
  logic [31:0] result;

  typedef struct {
    logic [31:0] r;
    logic        c, v, z;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          errs = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] last_r = '0;

  seq_add32 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares each done against the oldest expectation, and watches result stay put otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_r = '0;
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result",    result,           e.r);
        chk("carry_out", {31'd0, carry_out}, {31'd0, e.c});
        chk("overflow",  {31'd0, overflow},  {31'd0, e.v});
        chk("zero",      {31'd0, zero},      {31'd0, e.z});
        chk("done_cycle", cyc,             e.cyc);
        chk("ready_in_done", {31'd0, ready}, 32'd1);
        last_r = e.r;
      end
    end else begin
      chk("hold_result", result, last_r);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Accept edge comes after cyc+1; done is seen three edges later.
  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                       input logic [31:0] er, input logic ec, input logic ev, input logic ez);
    @(negedge clk);
    wait_ready();
    a = ia; b = ib; sub = isub; start = 1'b1;
    sb.push_back('{er, ec, ev, ez, cyc + 4});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_ready",  {31'd0, ready}, 32'd1);
    chk("rst_busy",   {31'd0, busy},  32'd0);
    chk("rst_done",   {31'd0, done},  32'd0);
    chk("rst_result", result,         32'd0);
    chk("rst_zero",   {31'd0, zero},  32'd1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_result", result, 32'd0);

    do_op(32'h0000_0FFF, 32'h0000_0001, 1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    do_op(32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    do_op(32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    do_op(32'h0000_1000, 32'h0000_0001, 1'b1, 32'h0000_0FFF, 1'b1, 1'b0, 1'b0);
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    // start held high; operands scrambled while busy; second op enters in the done cycle
    @(negedge clk);
    wait_ready();
    a = 32'h0000_FFFF; b = 32'h00FF_0001; sub = 1'b0; start = 1'b1;
    sb.push_back('{32'h0100_0000, 1'b0, 1'b0, 1'b0, cyc + 4});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 32'hDEAD_BEEF ^ i; b = 32'h5555_AAAA + i; sub = i[0];
      chk("busy_while_op", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    a = 32'h8000_0000; b = 32'h8000_0000; sub = 1'b0;
    sb.push_back('{32'h0000_0000, 1'b1, 1'b1, 1'b1, cyc + 4});
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 32'hCAFE_F00D + i; b = 32'h0BAD_0BAD ^ i; sub = ~i[0];
    end
    @(negedge clk);
    start = 1'b0;

    // reset during S1 drops the operation with no done
    @(negedge clk);
    wait_ready();
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_result", result,         32'd0);
    chk("midrst_ready",  {31'd0, ready}, 32'd1);
    chk("midrst_done",   {31'd0, done},  32'd0);
    chk("midrst_zero",   {31'd0, zero},  32'd1);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_ready",  {31'd0, ready}, 32'd1);
    chk("post_rst_result", result,         32'd0);
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
